// File: rtl/riscv_data_mem.sv
// riscv_data_mem: data-side bus responder with programmable wait states.
// Accepts one request at a time, waits WAIT_CYCLES cycles, then performs
// a byte-masked write or a full-word read on an internal word-addressed
// RAM and pulses data_bif_ack for one cycle. Read data is valid in the
// ack cycle and otherwise holds its last read value.
// Optional feature: define RISCV_DMEM_ERR_EN to add data_bif_err, which
// flags accesses whose address bits above the RAM range are nonzero.
module riscv_data_mem #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_bif_req,
  input  logic [31:0] data_bif_addr,
  input  logic        data_bif_rnw,
  input  logic [3:0]  data_bif_wmask,
  input  logic [31:0] data_bif_wdata,
  output logic [31:0] data_bif_rdata,
  output logic        data_bif_ack
`ifdef RISCV_DMEM_ERR_EN
  ,
  output logic        data_bif_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t state, next_state;
  logic [3:0] cnt;

  // Request fields captured at acceptance, so the access completes even if
  // the requester misbehaves and drops or changes them before ack.
  logic [ADDR_W-1:0] idx_q;
  logic              rnw_q;
  logic [3:0]        wmask_q;
  logic [31:0]       wdata_q;
  logic              oor_q;

  // Fields actually used for the RAM access on the commit edge.
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_rnw;
  logic [3:0]        acc_wmask;
  logic [31:0]       acc_wdata;
  logic              acc_oor;
  logic              req_oor;
  logic              commit;

  logic [31:0] mem [2**ADDR_W];

  // Word-offset bits never matter; upper bits matter only with error checking.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_bif_addr[1:0], data_bif_addr[31:ADDR_W+2]};

`ifdef RISCV_DMEM_ERR_EN
  assign req_oor = |data_bif_addr[31:ADDR_W+2];
`else
  assign req_oor = 1'b0;
`endif

  assign data_bif_ack = (state == S_ACK);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; the commit edge is the one that enters ACK.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_state = state;
    case (state)
      S_IDLE:  if (data_bif_req) next_state = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
      S_WAIT:  if (cnt == 4'd0) next_state = S_ACK;
      S_ACK:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    commit = (next_state == S_ACK);
  end

  // With zero wait states the access commits on the acceptance edge itself,
  // so in IDLE the live request fields feed the RAM instead of the latches.
  always_comb begin
    acc_idx   = idx_q;
    acc_rnw   = rnw_q;
    acc_wmask = wmask_q;
    acc_wdata = wdata_q;
    acc_oor   = oor_q;
    if (state == S_IDLE) begin
      acc_idx   = data_bif_addr[ADDR_W+1:2];
      acc_rnw   = data_bif_rnw;
      acc_wmask = data_bif_wmask;
      acc_wdata = data_bif_wdata;
      acc_oor   = req_oor;
    end
  end

  // Wait-state counter: loaded at acceptance, counts down in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst)                                   cnt <= 4'd0;
    else if (state == S_IDLE && data_bif_req)  cnt <= WAIT_LOAD;
    else if (state == S_WAIT && cnt != 4'd0)   cnt <= cnt - 4'd1;
  end

  // Capture the request at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      rnw_q   <= 1'b0;
      wmask_q <= 4'd0;
      wdata_q <= 32'd0;
      oor_q   <= 1'b0;
    end else if (state == S_IDLE && data_bif_req) begin
      idx_q   <= data_bif_addr[ADDR_W+1:2];
      rnw_q   <= data_bif_rnw;
      wmask_q <= data_bif_wmask;
      wdata_q <= data_bif_wdata;
      oor_q   <= req_oor;
    end
  end

  // Byte-lane RAM write on the commit edge; suppressed while reset is held.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset so it maps onto block RAM; its contents survive rst.
    if (!rst && commit && !acc_rnw && !acc_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wmask[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  // Read data register: loads on a read commit, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  data_bif_rdata <= 32'd0;
    else if (commit && acc_rnw) data_bif_rdata <= acc_oor ? 32'd0 : mem[acc_idx];
  end

`ifdef RISCV_DMEM_ERR_EN
  // Error flag is high only in the ack cycle of an out-of-range access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_bif_err <= 1'b0;
    else     data_bif_err <= commit && acc_oor;
  end
`endif

endmodule

// File: tb/tb_riscv_data_mem.sv
// Self-checking bench for riscv_data_mem: three instances with 0, 1 and 3
// wait states, checked against a word-array reference model of the RAM.
module tb_riscv_data_mem;

  localparam int ADDR_W = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, rnw, ack, err;
  logic [31:0] addr  [3];
  logic [3:0]  wmask [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem   [3][2**ADDR_W];
  logic [31:0] model_rdata [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    riscv_data_mem #(
      .ADDR_W(ADDR_W),
      .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .data_bif_req(req[g]),
      .data_bif_addr(addr[g]),
      .data_bif_rnw(rnw[g]),
      .data_bif_wmask(wmask[g]),
      .data_bif_wdata(wdata[g]),
      .data_bif_rdata(rdata[g]),
      .data_bif_ack(ack[g])
`ifdef RISCV_DMEM_ERR_EN
      ,
      .data_bif_err(err[g])
`endif
    );
  end

`ifndef RISCV_DMEM_ERR_EN
  assign err = 3'b000;
`endif

  function automatic int wc(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
  endfunction

  // Reference model: apply one access, return expected rdata and err.
  task automatic model_access(input int g, input logic [31:0] a, input logic r,
                              input logic [3:0] m, input logic [31:0] d,
                              output logic [31:0] exp_rd, output logic exp_err);
    int idx;
    logic oor;
    idx = int'(a[ADDR_W+1:2]);
`ifdef RISCV_DMEM_ERR_EN
    oor = (a >> (ADDR_W + 2)) != 0;
`else
    oor = 1'b0;
`endif
    if (r) model_rdata[g] = oor ? 32'h0 : model_mem[g][idx];
    else if (!oor)
      for (int i = 0; i < 4; i++)
        if (m[i]) model_mem[g][idx][8*i +: 8] = d[8*i +: 8];
    exp_rd  = model_rdata[g];
    exp_err = oor;
  endtask

  // Drive one request, wait (bounded) for its ack, then release it.
  task automatic bus_txn(input int g, input logic [31:0] a, input logic r,
                         input logic [3:0] m, input logic [31:0] d,
                         output logic [31:0] rd, output logic e,
                         output int lat, output logic ack_after);
    @(negedge clk);
    req[g] = 1'b1; addr[g] = a; rnw[g] = r; wmask[g] = m; wdata[g] = d;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ack[g]) break;
    end
    rd = rdata[g];
    e  = err[g];
    @(negedge clk);
    req[g] = 1'b0;
    @(posedge clk); #1;
    ack_after = ack[g];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 3'b000; rnw = 3'b000;
    for (int g = 0; g < 3; g++) begin
      addr[g] = 32'h0; wmask[g] = 4'h0; wdata[g] = 32'h0; model_rdata[g] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({ack[g], err[g], rdata[g]} !== 34'h0) begin
        errors++;
        $display("FAIL reset g=%0d: ack=%b err=%b rdata=%h, required all zero", g, ack[g], err[g], rdata[g]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Fill words 0..63 of each instance; checks acceptance-to-ack latency.
  task automatic test_preload();
    logic [31:0] rd, er; logic e, ee, aa; int lat;
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < 64; i++) begin
        logic [31:0] d;
        d = $urandom;
        model_access(g, 32'(i * 4), 1'b0, 4'hF, d, er, ee);
        bus_txn(g, 32'(i * 4), 1'b0, 4'hF, d, rd, e, lat, aa);
        checks++;
        if (lat !== wc(g) + 1 || aa !== 1'b0 || rd !== er) begin
          errors++;
          $display("FAIL preload g=%0d i=%0d: lat=%0d ack_after=%b rdata=%h, required lat=%0d ack_after=0 rdata=%h",
                   g, i, lat, aa, rd, wc(g) + 1, er);
        end
      end
  endtask

  // Table-driven sequence on one instance; each row checked on its own.
  task automatic run_table(input string name, input int g, input int n,
                           input logic [31:0] ta [8], input logic tr [8],
                           input logic [3:0] tm [8], input logic [31:0] td [8]);
    logic [31:0] rd, er; logic e, ee, aa; int lat;
    for (int k = 0; k < n; k++) begin
      model_access(g, ta[k], tr[k], tm[k], td[k], er, ee);
      bus_txn(g, ta[k], tr[k], tm[k], td[k], rd, e, lat, aa);
      checks++;
      if (lat !== wc(g) + 1 || rd !== er || e !== ee || aa !== 1'b0) begin
        errors++;
        $display("FAIL %s step %0d: lat=%0d rdata=%h err=%b ack_after=%b, required lat=%0d rdata=%h err=%b ack_after=0",
                 name, k, lat, rd, e, aa, wc(g) + 1, er, ee);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] ta [8]; logic tr [8]; logic [3:0] tm [8]; logic [31:0] td [8];
    ta = '{32'h10, 32'h10, 0, 0, 0, 0, 0, 0};
    tr = '{1'b0, 1'b1, 0, 0, 0, 0, 0, 0};
    tm = '{4'hF, 4'h0, 0, 0, 0, 0, 0, 0};
    td = '{32'hDEADBEEF, 32'h0, 0, 0, 0, 0, 0, 0};
    run_table("basic", 1, 2, ta, tr, tm, td);
    checks++;
    if (model_rdata[1] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_model: model=%h required=deadbeef", model_rdata[1]);
    end
  endtask

  task automatic test_byte_mask();
    logic [31:0] ta [8]; logic tr [8]; logic [3:0] tm [8]; logic [31:0] td [8];
    ta = '{32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 0, 0};
    tr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0};
    tm = '{4'hF, 4'b0101, 4'hA, 4'h0, 4'hF, 4'h0, 0, 0};
    td = '{32'h11223344, 32'hAABBCCDD, 32'hFFFFFFFF, 32'h99999999, 32'h12345678, 32'h0, 0, 0};
    run_table("byte_mask", 1, 6, ta, tr, tm, td);
    checks++;
    if (model_rdata[1] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_mask_model: model=%h required=11bb33dd", model_rdata[1]);
    end
  endtask

  // req held high across four reads: one ack per request, fixed spacing.
  task automatic test_back_to_back(input int g);
    logic [31:0] exp_rd [4]; logic [31:0] a [4]; logic ee;
    int k, last, budget;
    for (int i = 0; i < 4; i++) begin
      a[i] = 32'(($urandom_range(0, 63) * 4));
      model_access(g, a[i], 1'b1, 4'h0, 32'h0, exp_rd[i], ee);
    end
    budget = 4 * (wc(g) + 2) + 8;
    k = 0; last = -1;
    @(negedge clk);
    req[g] = 1'b1; rnw[g] = 1'b1; addr[g] = a[0];
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(posedge clk); #1;
      if (ack[g]) begin
        checks++;
        if (k >= 4 || rdata[g] !== exp_rd[k % 4] ||
            (k == 0 && cyc !== wc(g)) || (k > 0 && cyc - last !== wc(g) + 2)) begin
          errors++;
          $display("FAIL back_to_back g=%0d ack#%0d at cyc %0d (prev %0d): rdata=%h, required rdata=%h spacing=%0d",
                   g, k, cyc, last, rdata[g], exp_rd[k % 4], wc(g) + 2);
        end
        last = cyc;
        k++;
        @(negedge clk);
        if (k < 4) addr[g] = a[k];
        else       req[g] = 1'b0;
      end
    end
    checks++;
    if (k !== 4) begin
      errors++;
      $display("FAIL back_to_back_count g=%0d: acks=%0d required=4", g, k);
    end
  endtask

  // Reset in the second wait cycle aborts a pending write on the 3-wait DUT.
  task automatic test_reset_wait();
    logic [31:0] rd, er; logic e, ee, aa; int lat, acks;
    @(negedge clk);
    req[2] = 1'b1; addr[2] = 32'h30; rnw[2] = 1'b0; wmask[2] = 4'hF; wdata[2] = 32'h55;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    req[2] = 1'b0;
    for (int g = 0; g < 3; g++) model_rdata[g] = 32'h0;
    #1;
    checks++;
    if ({ack[2], err[2], rdata[2]} !== 34'h0) begin
      errors++;
      $display("FAIL reset_wait_outputs: ack=%b err=%b rdata=%h, required all zero", ack[2], err[2], rdata[2]);
    end
    acks = 0;
    repeat (2) begin @(posedge clk); #1; acks += int'(ack[2]); end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin @(posedge clk); #1; acks += int'(ack[2]); end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL reset_wait_ack: acks=%0d required=0", acks);
    end
    model_access(2, 32'h30, 1'b1, 4'h0, 32'h0, er, ee);
    bus_txn(2, 32'h30, 1'b1, 4'h0, 32'h0, rd, e, lat, aa);
    checks++;
    if (rd !== er || lat !== 4) begin
      errors++;
      $display("FAIL reset_wait_read: rdata=%h lat=%0d, required rdata=%h lat=4", rd, lat, er);
    end
  endtask

  task automatic test_addressing();
    logic [31:0] ta [8]; logic tr [8]; logic [3:0] tm [8]; logic [31:0] td [8];
    ta = '{32'h13, 32'h1010, 32'h12, 32'h1011, 0, 0, 0, 0};
    tr = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0};
    tm = '{4'hF, 4'hF, 4'hF, 4'hF, 0, 0, 0, 0};
    td = '{32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0};
    run_table("addressing", 1, 4, ta, tr, tm, td);
  endtask

  // Out-of-range write then reads; aliases in the default build.
  task automatic test_err();
    logic [31:0] ta [8]; logic tr [8]; logic [3:0] tm [8]; logic [31:0] td [8];
    ta = '{32'h1010, 32'h10, 32'h1010, 32'hFFC0_0010, 32'h10, 0, 0, 0};
    tr = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 0};
    tm = '{4'hF, 4'h0, 4'h0, 4'h3, 4'h0, 0, 0, 0};
    td = '{32'hCAFEF00D, 32'h0, 32'h0, 32'h5A5A5A5A, 32'h0, 0, 0, 0};
    run_table("err", 1, 5, ta, tr, tm, td);
    run_table("err_w0", 0, 5, ta, tr, tm, td);
  endtask

  task automatic test_random();
    logic [31:0] rd, er; logic e, ee, aa; int lat;
    for (int g = 0; g < 3; g++)
      for (int n = 0; n < 40; n++) begin
        logic [31:0] a, d; logic r; logic [3:0] m;
        a = 32'(($urandom_range(0, 63) * 4)) | 32'($urandom_range(0, 3));
        r = 1'($urandom);
        m = 4'($urandom);
        d = $urandom;
        model_access(g, a, r, m, d, er, ee);
        bus_txn(g, a, r, m, d, rd, e, lat, aa);
        checks++;
        if (lat !== wc(g) + 1 || rd !== er || e !== ee || aa !== 1'b0) begin
          errors++;
          $display("FAIL random g=%0d n=%0d a=%h rnw=%b m=%h: lat=%0d rdata=%h err=%b, required lat=%0d rdata=%h err=%b",
                   g, n, a, r, m, lat, rd, e, wc(g) + 1, er, ee);
        end
      end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_basic();
    test_byte_mask();
    test_back_to_back(0);
    test_back_to_back(2);
    test_back_to_back(1);
    test_reset_wait();
    test_addressing();
    test_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/riscv_data_mem.md
Name: riscv_data_mem

Overview:
Data-side bus responder: the target end of the data_bif interface driven by the core's memory stage and consumed by its writeback stage.
- Accepts one request at a time.
- Inserts a programmable number of wait states.
- Performs byte-masked writes or full-word reads on an internal word-addressed RAM.
- Returns a single-cycle ack, with read data valid in the ack cycle.

Parameters:
- ADDR_W, 10, word-address width; RAM depth is 2^ADDR_W words of 32 bits (4 KiB by default).
- WAIT_CYCLES, 1, wait states between acceptance and ack (0..15).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_bif_req  input  1  request valid; held with all request fields stable until ack.
- data_bif_addr  input  32  byte address; bits [1:0] ignored, word index = addr[ADDR_W+1:2].
- data_bif_rnw  input  1  1 = read, 0 = write.
- data_bif_wmask  input  4  byte enables for writes; bit i selects byte lane [8i+7:8i].
- data_bif_wdata  input  32  write data.
- data_bif_rdata  output  32  read data; valid only while data_bif_ack=1.
- data_bif_ack  output  1  one-cycle completion pulse.

Behaviour:
Reset (asynchronous, while rst=1):
- State goes to IDLE; data_bif_ack=0; data_bif_rdata=0; wait counter=0.
- RAM contents are not cleared.

States: IDLE, WAIT, ACK.
- IDLE: if req=1, latch the word index, rnw, wmask and wdata.
  - If WAIT_CYCLES=0, go to ACK.
  - Otherwise load the counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: if counter=0, go to ACK; otherwise decrement.
- ACK: ack=1 for exactly this cycle; next state is IDLE unconditionally.
  - req is ignored in ACK, so the held request cannot be double-accepted.

Commit point: the RAM access happens on the edge entering ACK.
- Read: rdata is registered from RAM[index].
- Write: each lane with wmask[i]=1 takes wdata lane i; other lanes are unchanged; rdata holds its previous value.

Latency and throughput:
- Request sampled in IDLE at edge E gives ack high during cycle E+1+WAIT_CYCLES.
- Back-to-back requests complete at one per WAIT_CYCLES+2 cycles; the new request is sampled in the IDLE cycle following ACK.

Boundary conditions:
- wmask=4'b0000 write: ack is given, RAM is unchanged.
- rnw=1: wmask and wdata are ignored.
- Read-after-write to the same address returns the new data, because the write commits before the next acceptance.
- req dropped before ack (protocol violation): the transaction still completes from latched fields.
- Reset asserted in WAIT: the transaction is aborted; no write is committed; no ack.
- Reset asserted in ACK: ack drops immediately (asynchronous); the write already committed stays committed.
- Address bits above ADDR_W+1 are ignored (aliasing), unless the optional feature is compiled in.
- rdata holds its last read value between acks.

Optional Feature:
Macro: RISCV_DMEM_ERR_EN.

Defined:
- Adds output data_bif_err (1 bit), reset value 0.
- A request with addr[31:ADDR_W+2]≠0 is out of range and is still acked on the normal timing, with data_bif_err=1 in the ack cycle.
- An out-of-range write does not modify RAM.
- An out-of-range read returns rdata=32'h0.
- data_bif_err=0 in all other cycles.

Undefined:
- No data_bif_err port.
- Upper address bits are ignored, so accesses alias into the RAM.

Test Plan:
1. WAIT_CYCLES=1: write addr 0x10, wdata 0xDEADBEEF, wmask 4'hF, then read 0x10. Required: write ack 2 cycles after acceptance edge; read ack cycle shows rdata=0xDEADBEEF.
2. Byte masks: write 0x11223344 with mask F to 0x20, then 0xAABBCCDD with mask 4'b0101, then read 0x20. Required: rdata=0x11BB33DD; a mask-0 write leaves it unchanged.
3. WAIT_CYCLES=0 and WAIT_CYCLES=3, req held high continuously with 4 reads. Required: ack spacing of 2 and 5 cycles respectively; exactly one ack per request; rdata matches preloaded words.
4. Reset in WAIT: issue write 0x55 to 0x30 with WAIT_CYCLES=3, assert rst in the 2nd wait cycle, release, read 0x30. Required: no ack during or after reset for the aborted write; read returns the old value; outputs are 0 during reset.
5. Addressing: read addr 0x13 returns word 0x10; with ADDR_W=10, addr 0x1010 aliases to 0x10 without RISCV_DMEM_ERR_EN.
6. With RISCV_DMEM_ERR_EN: write to 0x1010, then read 0x10 and 0x1010. Required: the write acks with err=1 and leaves 0x10 unchanged; the 0x1010 read gives err=1 and rdata=0; the 0x10 read gives err=0.
